// File: rtl/scroll_ticker_pkg.sv
// Shared character/segment definitions for the scrolling seven-segment ticker.
package scroll_ticker_pkg;
  localparam int CODE_W = 2;

  typedef logic [CODE_W-1:0] code_t;
  typedef logic [6:0]        seg_t;   // bit 0 = a ... bit 6 = g, active low

  localparam code_t CH_D     = 2'd0;
  localparam code_t CH_E     = 2'd1;
  localparam code_t CH_1     = 2'd2;
  localparam code_t CH_BLANK = 2'd3;

  localparam seg_t SEG_D     = 7'b0100001;
  localparam seg_t SEG_E     = 7'b0000110;
  localparam seg_t SEG_1     = 7'b1111001;
  localparam seg_t SEG_BLANK = 7'b1111111;
endpackage

// File: rtl/scroll_ticker_if.sv
// Control/write/display bundle for scroll_ticker. SCROLL_TICKER_BOUNCE_EN adds the bounce input.
interface scroll_ticker_if
  import scroll_ticker_pkg::*;
#(
  parameter int NUM_DIGITS = 6,
  parameter int MSG_LEN    = 6
);
  localparam int AW = (MSG_LEN > 1) ? $clog2(MSG_LEN) : 1;

  logic                     run;
  logic                     dir;
  logic                     wr_en;
  logic [AW-1:0]            wr_addr;
  logic [CODE_W-1:0]        wr_data;
`ifdef SCROLL_TICKER_BOUNCE_EN
  logic                     bounce;
`endif
  logic [CODE_W*NUM_DIGITS-1:0] codes;
  logic [7*NUM_DIGITS-1:0]      hex;
  logic [AW-1:0]                pos;
  logic                         step;

`ifdef SCROLL_TICKER_BOUNCE_EN
  modport master (output run, dir, wr_en, wr_addr, wr_data, bounce,
                  input  codes, hex, pos, step);
  modport slave  (input  run, dir, wr_en, wr_addr, wr_data, bounce,
                  output codes, hex, pos, step);
`else
  modport master (output run, dir, wr_en, wr_addr, wr_data,
                  input  codes, hex, pos, step);
  modport slave  (input  run, dir, wr_en, wr_addr, wr_data,
                  output codes, hex, pos, step);
`endif
endinterface

// File: rtl/scroll_ticker_seg7_code_dec.sv
// One digit: 2-bit character code to active-low a..g segments.
module seg7_code_dec
  import scroll_ticker_pkg::*;
(
  input  code_t code,
  output seg_t  seg
);
  always_comb begin
    seg = SEG_BLANK;
    case (code)
      CH_D:    seg = SEG_D;
      CH_E:    seg = SEG_E;
      CH_1:    seg = SEG_1;
      default: seg = SEG_BLANK;
    endcase
  end
endmodule

// File: rtl/scroll_ticker.sv
// Scrolling message window on NUM_DIGITS seven-segment digits.
// Optional SCROLL_TICKER_BOUNCE_EN: ping-pong scrolling within 0..MSG_LEN-NUM_DIGITS.
module scroll_ticker
  import scroll_ticker_pkg::*;
#(
  parameter int NUM_DIGITS = 6,
  parameter int MSG_LEN    = 6,
  parameter int DIV_COUNT  = 50_000_000
)(
  input  logic          CLOCK_50,
  input  logic          reset,
  scroll_ticker_if.slave bus
);
  localparam int AW  = (MSG_LEN > 1) ? $clog2(MSG_LEN) : 1;
  localparam int CW  = $clog2(DIV_COUNT);
  localparam int LIM = MSG_LEN - NUM_DIGITS;

  typedef logic [AW-1:0] pos_t;

  logic [CW-1:0]                      cnt;
  pos_t                               pos_q, pos_nxt;
  logic                               tick, step_q;
  logic [MSG_LEN-1:0][CODE_W-1:0]     msg;
  logic [NUM_DIGITS-1:0][CODE_W-1:0]  win, codes_q;
  logic [NUM_DIGITS-1:0][6:0]         seg;

  assign tick = bus.run && (cnt == CW'(DIV_COUNT - 1));

  function automatic pos_t circ_next(pos_t p, logic d);
    if (!d) return (p == pos_t'(MSG_LEN - 1)) ? '0 : p + 1'b1;
    return (p == '0) ? pos_t'(MSG_LEN - 1) : p - 1'b1;
  endfunction

`ifdef SCROLL_TICKER_BOUNCE_EN
  logic bdir_q, bdir_nxt;   // 0 = heading left (incrementing)

  always_comb begin
    pos_nxt  = circ_next(pos_q, bus.dir);
    bdir_nxt = bdir_q;
    if (bus.bounce) begin
      if (LIM <= 0) begin
        pos_nxt = '0;
      end else if (pos_q > pos_t'(LIM)) begin
        // re-enter the legal range from the top, heading right
        pos_nxt  = pos_t'(LIM);
        bdir_nxt = 1'b1;
      end else if (!bdir_q) begin
        if (pos_q == pos_t'(LIM)) begin
          pos_nxt  = pos_q - 1'b1;
          bdir_nxt = 1'b1;
        end else begin
          pos_nxt  = pos_q + 1'b1;
        end
      end else begin
        if (pos_q == '0) begin
          pos_nxt  = pos_t'(1);
          bdir_nxt = 1'b0;
        end else begin
          pos_nxt  = pos_q - 1'b1;
        end
      end
    end
  end

  always_ff @(posedge CLOCK_50) begin
    if (reset)     bdir_q <= 1'b0;
    else if (tick) bdir_q <= bdir_nxt;
  end
`else
  assign pos_nxt = circ_next(pos_q, bus.dir);
`endif

  // pos+k < 2*MSG_LEN, so one conditional subtract replaces the modulo
  for (genvar k = 0; k < NUM_DIGITS; k++) begin : g_win
    logic [AW:0] raw;
    pos_t        idx;
    assign raw = {1'b0, pos_q} + (AW+1)'(k);
    assign idx = pos_t'((raw >= (AW+1)'(MSG_LEN)) ? raw - (AW+1)'(MSG_LEN) : raw);
    assign win[NUM_DIGITS-1-k] = msg[idx];
  end

  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      cnt     <= '0;
      pos_q   <= '0;
      msg     <= {MSG_LEN{CH_BLANK}};
      codes_q <= '1;
      step_q  <= 1'b0;
    end else begin
      if (tick) begin
        cnt   <= '0;
        pos_q <= pos_nxt;
      end else if (bus.run) begin
        cnt   <= cnt + 1'b1;
      end
      step_q <= tick;
      if (bus.wr_en && ({1'b0, bus.wr_addr} < (AW+1)'(MSG_LEN)))
        msg[bus.wr_addr] <= bus.wr_data;
      codes_q <= win;
    end
  end

  for (genvar i = 0; i < NUM_DIGITS; i++) begin : g_dec
    seg7_code_dec u_dec (.code(codes_q[i]), .seg(seg[i]));
  end

  assign bus.codes = codes_q;
  assign bus.hex   = seg;
  assign bus.pos   = pos_q;
  assign bus.step  = step_q;
endmodule

// File: tb/tb_scroll_ticker.sv
// Directed bench for scroll_ticker: NUM_DIGITS=6, MSG_LEN=6, DIV_COUNT=4 (plus MSG_LEN=8 bounce unit when enabled).
module tb_scroll_ticker;
  logic CLOCK_50 = 1'b0;
  logic reset;
  int   checks = 0;
  int   errors = 0;
  int   msg_m [6];
  int   mpos;

  always #5 CLOCK_50 = ~CLOCK_50;

  scroll_ticker_if #(.NUM_DIGITS(6), .MSG_LEN(6)) bus ();
  scroll_ticker #(.NUM_DIGITS(6), .MSG_LEN(6), .DIV_COUNT(4)) dut (
    .CLOCK_50(CLOCK_50), .reset(reset), .bus(bus));

`ifdef SCROLL_TICKER_BOUNCE_EN
  scroll_ticker_if #(.NUM_DIGITS(6), .MSG_LEN(8)) ifb ();
  scroll_ticker #(.NUM_DIGITS(6), .MSG_LEN(8), .DIV_COUNT(4)) dut_b (
    .CLOCK_50(CLOCK_50), .reset(reset), .bus(ifb));
`endif

  task automatic clk();
    @(posedge CLOCK_50);
    #1;
  endtask

  function automatic logic [11:0] win_m(int p);
    logic [11:0] r = '0;
    for (int k = 0; k < 6; k++) r[2*(5-k) +: 2] = 2'(msg_m[(p + k) % 6]);
    return r;
  endfunction

  task automatic test_reset();
    reset = 1'b1;
    clk(); clk();
    reset = 1'b0;
    clk();
    checks++; if (bus.codes !== 12'hFFF) begin errors++; $display("FAIL reset_codes got=%h exp=fff", bus.codes); end
    checks++; if (bus.hex !== {42{1'b1}}) begin errors++; $display("FAIL reset_hex got=%h exp=all ones", bus.hex); end
    checks++; if (bus.pos !== 3'd0) begin errors++; $display("FAIL reset_pos got=%0d exp=0", bus.pos); end
    checks++; if (bus.step !== 1'b0) begin errors++; $display("FAIL reset_step got=%b exp=0", bus.step); end
    for (int i = 0; i < 6; i++) msg_m[i] = 3;
  endtask

  task automatic test_load();
    int data [6] = '{3, 3, 3, 0, 1, 2};
    for (int a = 0; a < 6; a++) begin
      bus.wr_en = 1'b1; bus.wr_addr = 3'(a); bus.wr_data = 2'(data[a]);
      msg_m[a] = data[a];
      clk();
    end
    bus.wr_en = 1'b0;
    clk();
    checks++; if (bus.codes !== 12'b111111000110) begin errors++; $display("FAIL load_codes got=%b exp=111111000110", bus.codes); end
    checks++;
    if (bus.hex !== {7'h7F, 7'h7F, 7'h7F, 7'b0100001, 7'b0000110, 7'b1111001}) begin
      errors++; $display("FAIL load_hex got=%h", bus.hex);
    end
    for (int c = 0; c < 20; c++) begin
      clk();
      checks++;
      if (bus.pos !== 3'd0 || bus.step !== 1'b0) begin
        errors++; $display("FAIL frozen_pos cycle=%0d pos=%0d step=%b exp pos=0 step=0", c, bus.pos, bus.step);
      end
    end
  endtask

  task automatic test_scroll_left();
    bus.run = 1'b1; bus.dir = 1'b0;
    mpos = 0;
    for (int s = 1; s <= 6; s++) begin
      for (int c = 1; c <= 4; c++) begin
        clk();
        if (c == 1) begin
          checks++;
          if (bus.codes !== win_m(mpos)) begin errors++; $display("FAIL scroll_codes step=%0d got=%b exp=%b", s, bus.codes, win_m(mpos)); end
        end
        if (s == 2 && c == 1) begin
          checks++; if (bus.codes !== 12'b111100011011) begin errors++; $display("FAIL scroll_codes_p1 got=%b exp=111100011011", bus.codes); end
        end
        if (s == 3 && c == 1) begin
          checks++; if (bus.codes !== 12'b110001101111) begin errors++; $display("FAIL scroll_codes_p2 got=%b exp=110001101111", bus.codes); end
        end
        if (c < 4) begin
          checks++; if (bus.step !== 1'b0) begin errors++; $display("FAIL step_early step=%0d c=%0d got=1 exp=0", s, c); end
        end else begin
          mpos = (mpos + 1) % 6;
          checks++;
          if (bus.step !== 1'b1 || bus.pos !== 3'(mpos)) begin
            errors++; $display("FAIL step_pos step=%0d step_got=%b pos=%0d exp pos=%0d", s, bus.step, bus.pos, mpos);
          end
        end
      end
    end
    checks++; if (bus.pos !== 3'd0) begin errors++; $display("FAIL wrap_pos got=%0d exp=0", bus.pos); end
  endtask

  task automatic test_dir_right();
    bus.dir = 1'b1;
    for (int c = 1; c <= 4; c++) clk();
    checks++; if (bus.step !== 1'b1 || bus.pos !== 3'd5) begin errors++; $display("FAIL dir_right step=%b pos=%0d exp 1/5", bus.step, bus.pos); end
    clk();
    checks++; if (bus.codes !== 12'b101111110001) begin errors++; $display("FAIL dir_right_codes got=%b exp=101111110001", bus.codes); end
    checks++; if (bus.step !== 1'b0) begin errors++; $display("FAIL dir_step_width got=%b exp=0", bus.step); end
    clk();
    bus.dir = 1'b0;   // flip mid-interval
    clk();
    checks++; if (bus.step !== 1'b0) begin errors++; $display("FAIL dir_mid_early got=%b exp=0", bus.step); end
    clk();
    checks++; if (bus.step !== 1'b1 || bus.pos !== 3'd0) begin errors++; $display("FAIL dir_mid step=%b pos=%0d exp 1/0", bus.step, bus.pos); end
  endtask

  task automatic test_pause();
    clk(); clk();
    bus.run = 1'b0;
    for (int c = 0; c < 3; c++) begin
      clk();
      checks++; if (bus.step !== 1'b0 || bus.pos !== 3'd0) begin errors++; $display("FAIL pause c=%0d step=%b pos=%0d exp 0/0", c, bus.step, bus.pos); end
    end
    bus.run = 1'b1;
    clk();
    checks++; if (bus.step !== 1'b0) begin errors++; $display("FAIL pause_resume_early got=%b exp=0", bus.step); end
    clk();
    checks++; if (bus.step !== 1'b1 || bus.pos !== 3'd1) begin errors++; $display("FAIL pause_delay step=%b pos=%0d exp 1/1", bus.step, bus.pos); end
  endtask

  task automatic test_write_tick();
    clk(); clk(); clk();
    bus.wr_en = 1'b1; bus.wr_addr = 3'd3; bus.wr_data = 2'd1;
    clk();
    bus.wr_en = 1'b0;
    msg_m[3] = 1;
    checks++; if (bus.step !== 1'b1 || bus.pos !== 3'd2) begin errors++; $display("FAIL wr_tick step=%b pos=%0d exp 1/2", bus.step, bus.pos); end
    bus.run = 1'b0;
    clk();
    checks++; if (bus.codes !== 12'b110101101111) begin errors++; $display("FAIL wr_tick_codes got=%b exp=110101101111", bus.codes); end
    checks++; if (bus.hex[28 +: 7] !== 7'b0000110) begin errors++; $display("FAIL wr_tick_hex4 got=%b exp=0000110", bus.hex[28 +: 7]); end
    bus.wr_en = 1'b1; bus.wr_addr = 3'd7; bus.wr_data = 2'd0;
    clk();
    bus.wr_addr = 3'd6;
    clk();
    bus.wr_en = 1'b0;
    clk();
    checks++; if (bus.codes !== win_m(2)) begin errors++; $display("FAIL wr_oob_codes got=%b exp=%b", bus.codes, win_m(2)); end
  endtask

  task automatic test_reset_override();
    bus.run = 1'b1; bus.wr_en = 1'b1; bus.wr_addr = 3'd0; bus.wr_data = 2'd0;
    reset = 1'b1;
    clk();
    reset = 1'b0; bus.wr_en = 1'b0; bus.run = 1'b0;
    clk();
    checks++; if (bus.codes !== 12'hFFF || bus.pos !== 3'd0 || bus.step !== 1'b0) begin
      errors++; $display("FAIL reset_override codes=%h pos=%0d step=%b exp fff/0/0", bus.codes, bus.pos, bus.step);
    end
  endtask

`ifdef SCROLL_TICKER_BOUNCE_EN
  task automatic test_bounce();
    int exp_seq [5] = '{1, 2, 1, 0, 1};
    checks++; if (ifb.pos !== 3'd0) begin errors++; $display("FAIL bounce_start got=%0d exp=0", ifb.pos); end
    ifb.bounce = 1'b1; ifb.run = 1'b1; ifb.dir = 1'b1;   // dir must be ignored
    for (int s = 0; s < 5; s++) begin
      for (int c = 0; c < 4; c++) clk();
      checks++;
      if (ifb.step !== 1'b1 || ifb.pos !== 3'(exp_seq[s])) begin
        errors++; $display("FAIL bounce step=%0d pos=%0d exp=%0d", s, ifb.pos, exp_seq[s]);
      end
    end
    ifb.run = 1'b0;
  endtask
`endif

  initial begin
    reset = 1'b1;
    bus.run = 1'b0; bus.dir = 1'b0; bus.wr_en = 1'b0; bus.wr_addr = '0; bus.wr_data = '0;
`ifdef SCROLL_TICKER_BOUNCE_EN
    bus.bounce = 1'b0;
    ifb.run = 1'b0; ifb.dir = 1'b0; ifb.wr_en = 1'b0; ifb.wr_addr = '0; ifb.wr_data = '0; ifb.bounce = 1'b0;
`endif
    test_reset();
    test_load();
    test_scroll_left();
    test_dir_right();
    test_pause();
    test_write_tick();
    test_reset_override();
`ifdef SCROLL_TICKER_BOUNCE_EN
    test_bounce();
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
